// File: rtl/frame_ingress_writer_if.sv
// Byte stream in, data FIFO and pointer FIFO writes out.
// master = stream source / FIFO side, slave = ingress writer.
interface frame_ingress_writer_if;
  logic        in_sof;
  logic        in_dv;
  logic [7:0]  in_data;
  logic [1:0]  in_port;
  logic        in_ready;
  logic        sfifo_wr;
  logic [7:0]  sfifo_din;
  logic [11:0] sfifo_free;
  logic        ptr_sfifo_wr;
  logic [15:0] ptr_sfifo_din;
  logic        ptr_sfifo_full;

  modport master (
    output in_sof, in_dv, in_data, in_port,
    output sfifo_free, ptr_sfifo_full,
    input  in_ready, sfifo_wr, sfifo_din,
    input  ptr_sfifo_wr, ptr_sfifo_din
  );

  modport slave (
    input  in_sof, in_dv, in_data, in_port,
    input  sfifo_free, ptr_sfifo_full,
    output in_ready, sfifo_wr, sfifo_din,
    output ptr_sfifo_wr, ptr_sfifo_din
  );
endinterface

// File: rtl/frame_ingress_writer.sv
// Ingress writer: copies frames into sfifo, pads/truncates,
// then pushes a {portmap,len} descriptor into ptr_sfifo.
module frame_ingress_writer #(
  parameter int MIN_LEN  = 60,
  parameter int MAX_LEN  = 1518,
  parameter int FREE_REQ = 1518
) (
  input  logic        clk,
  input  logic        rst,
  frame_ingress_writer_if.slave bus,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] trunc_cnt
);

  typedef enum logic [2:0] {
    IDLE, WRITE, PAD, COMMIT, DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic        trunc_q, trunc_d;
  logic [3:0]  pmap_q, pmap_d;
  logic        skip_q, skip_d;
  logic        rdy_q, rdy_d;
  logic        wr_q, wr_d;
  logic [7:0]  din_q, din_d;
  logic        pwr_q, pwr_d;
  logic [15:0] pdin_q, pdin_d;
  logic [15:0] fcnt_q, dcnt_q, tcnt_q;
  logic        f_inc, d_inc, t_inc;
  logic        sof, room;

  assign sof  = bus.in_sof & bus.in_dv;
  assign room = (bus.sfifo_free >= 12'(FREE_REQ))
              & ~bus.ptr_sfifo_full;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    pmap_d  = pmap_q;
    skip_d  = skip_q & bus.in_dv;
    wr_d    = 1'b0;
    din_d   = 8'h00;
    pwr_d   = 1'b0;
    pdin_d  = 16'h0000;
    f_inc   = 1'b0;
    d_inc   = 1'b0;
    t_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sof) begin
          if (room) begin
            pmap_d  = 4'd1 << bus.in_port;
            wr_d    = 1'b1;
            din_d   = bus.in_data;
            len_d   = 11'd1;
            trunc_d = 1'b0;
            state_d = WRITE;
          end else begin
            d_inc   = 1'b1;
            state_d = DISCARD;
          end
        end
      end
      WRITE: begin
        if (bus.in_dv) begin
          if (len_q < 11'(MAX_LEN)) begin
            wr_d  = 1'b1;
            din_d = bus.in_data;
            len_d = len_q + 11'd1;
          end else begin
            trunc_d = 1'b1;
          end
        end else if (len_q < 11'(MIN_LEN)) begin
          state_d = PAD;
        end else begin
          state_d = COMMIT;
        end
      end
      PAD: begin
        wr_d  = 1'b1;
        len_d = len_q + 11'd1;
        if (len_d == 11'(MIN_LEN)) state_d = COMMIT;
        // A frame starting now is dropped but the pad still completes.
        if (sof) begin
          d_inc  = 1'b1;
          skip_d = 1'b1;
        end
      end
      COMMIT: begin
        pwr_d  = 1'b1;
        pdin_d = {1'b0, pmap_q, len_q};
        f_inc  = 1'b1;
        t_inc  = trunc_q;
        if (sof) d_inc = 1'b1;
        state_d = (sof | skip_d) ? DISCARD : IDLE;
      end
      DISCARD: begin
        if (sof) d_inc = 1'b1;
        if (!bus.in_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      trunc_q <= 1'b0;
      pmap_q  <= '0;
      skip_q  <= 1'b0;
      rdy_q   <= 1'b1;
      wr_q    <= 1'b0;
      din_q   <= '0;
      pwr_q   <= 1'b0;
      pdin_q  <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      pmap_q  <= pmap_d;
      skip_q  <= skip_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      pwr_q   <= pwr_d;
      pdin_q  <= pdin_d;
      if (f_inc && fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 16'd1;
      if (d_inc && dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 16'd1;
      if (t_inc && tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
    end
  end

  assign bus.in_ready      = rdy_q;
  assign bus.sfifo_wr      = wr_q;
  assign bus.sfifo_din     = din_q;
  assign bus.ptr_sfifo_wr  = pwr_q;
  assign bus.ptr_sfifo_din = pdin_q;
  assign frame_cnt         = fcnt_q;
  assign drop_cnt          = dcnt_q;
  assign trunc_cnt         = tcnt_q;

endmodule
